// File: rtl/sram_arb_pkg.sv
// Shared constants and the two-way round-robin helper for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 32;
  localparam int RSP_DEPTH_DEF = 4;

  localparam logic REQ_MGMT = 1'b0;
  localparam logic REQ_DSP  = 1'b1;

  // Returns one-hot {gnt1, gnt0}; on contention the requester not granted last wins.
  function automatic logic [1:0] rr_grant(input logic cand0, input logic cand1, input logic last);
    logic [1:0] g;
    g = 2'b00;
    if (cand0 && cand1) begin
      g = (last == REQ_MGMT) ? 2'b10 : 2'b01;
    end else if (cand0) begin
      g = 2'b01;
    end else if (cand1) begin
      g = 2'b10;
    end else begin
      g = 2'b00;
    end
    return g;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester handshakes, response streams and SRAM W0/R0 wires of the arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_we, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              sram_W0_en;
  logic [ADDR_W-1:0] sram_W0_addr;
  logic [DATA_W-1:0] sram_W0_data;
  logic              sram_R0_en;
  logic [ADDR_W-1:0] sram_R0_addr;
  logic [DATA_W-1:0] sram_R0_data;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
    input  req0_wdata, req1_wdata, rsp0_ready, rsp1_ready, sram_R0_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    output sram_W0_en, sram_W0_addr, sram_W0_data, sram_R0_en, sram_R0_addr
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
    output req0_wdata, req1_wdata, rsp0_ready, rsp1_ready, sram_R0_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    input  sram_W0_en, sram_W0_addr, sram_W0_data, sram_R0_en, sram_R0_addr
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; simultaneous push and pop are both honoured.
module sram_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s, do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  sram_rsp_fifo_chk u_chk (.clk(clk), .rst(rst), .push(push), .pop(do_pop_s), .full(full));
endmodule

// File: rtl/sram_rsp_fifo_chk.sv
// Flags a push into a full response FIFO that is not relieved by a same-cycle pop.
module sram_rsp_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);
  // overflow watch, ignored while in reset
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop));
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a 1W/1R SRAM: independent round-robin per port,
// registered SRAM controls, per-requester credit-limited response FIFOs.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  sram_port_arbiter_if.slave  bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic              wr_last_r, rd_last_r;
  logic              s1_valid_r, s1_id_r, s2_valid_r, s2_id_r;
  logic [1:0]        wpick_s, wgnt_s, rcand_s, rpick_s, rgnt_s;
  logic [ADDR_W-1:0] waddr_s, raddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              collide_s;
  logic [CW-1:0]     cnt0_s, cnt1_s;
  logic [CW:0]       occ0_s, occ1_s;
  logic              empty0_s, empty1_s, full0_s, full1_s;
  logic              push0_s, push1_s, pop0_s, pop1_s;

  // arbitration, credit check and same-address collision deferral
  always_comb begin
    occ0_s = {1'b0, cnt0_s} + (CW+1)'(s1_valid_r && (s1_id_r == REQ_MGMT))
                            + (CW+1)'(s2_valid_r && (s2_id_r == REQ_MGMT));
    occ1_s = {1'b0, cnt1_s} + (CW+1)'(s1_valid_r && (s1_id_r == REQ_DSP))
                            + (CW+1)'(s2_valid_r && (s2_id_r == REQ_DSP));
    wpick_s    = rr_grant(bus.req0_valid & bus.req0_we, bus.req1_valid & bus.req1_we, wr_last_r);
    rcand_s[0] = bus.req0_valid & ~bus.req0_we & ~full0_s & (occ0_s < (CW+1)'(RSP_DEPTH));
    rcand_s[1] = bus.req1_valid & ~bus.req1_we & ~full1_s & (occ1_s < (CW+1)'(RSP_DEPTH));
    rpick_s    = rr_grant(rcand_s[0], rcand_s[1], rd_last_r);
    waddr_s    = wpick_s[1] ? bus.req1_addr  : bus.req0_addr;
    wdata_s    = wpick_s[1] ? bus.req1_wdata : bus.req0_wdata;
    raddr_s    = rpick_s[1] ? bus.req1_addr  : bus.req0_addr;
    collide_s  = (|wpick_s) && (|rpick_s) && (waddr_s == raddr_s);
    if (wb_rst_i) begin
      wgnt_s = 2'b00;
      rgnt_s = 2'b00;
    end else if (collide_s) begin
      wgnt_s = wpick_s;
      rgnt_s = 2'b00;
    end else begin
      wgnt_s = wpick_s;
      rgnt_s = rpick_s;
    end
    bus.req0_ready = wgnt_s[0] | rgnt_s[0];
    bus.req1_ready = wgnt_s[1] | rgnt_s[1];
  end

  // registered SRAM controls, round-robin pointers and read-tag pipeline
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus.sram_W0_en   <= 1'b0;
      bus.sram_W0_addr <= {ADDR_W{1'b0}};
      bus.sram_W0_data <= {DATA_W{1'b0}};
      bus.sram_R0_en   <= 1'b0;
      bus.sram_R0_addr <= {ADDR_W{1'b0}};
      wr_last_r        <= REQ_DSP;
      rd_last_r        <= REQ_DSP;
      s1_valid_r       <= 1'b0;
      s1_id_r          <= REQ_MGMT;
      s2_valid_r       <= 1'b0;
      s2_id_r          <= REQ_MGMT;
    end else begin
      bus.sram_W0_en <= |wgnt_s;
      if (|wgnt_s) begin
        bus.sram_W0_addr <= waddr_s;
        bus.sram_W0_data <= wdata_s;
        wr_last_r        <= wgnt_s[1];
      end
      bus.sram_R0_en <= |rgnt_s;
      if (|rgnt_s) begin
        bus.sram_R0_addr <= raddr_s;
        rd_last_r        <= rgnt_s[1];
      end
      s1_valid_r <= |rgnt_s;
      s1_id_r    <= rgnt_s[1];
      s2_valid_r <= s1_valid_r;
      s2_id_r    <= s1_id_r;
    end
  end

  // stage 2 lines up with sram_R0_data being valid
  assign push0_s        = s2_valid_r & (s2_id_r == REQ_MGMT);
  assign push1_s        = s2_valid_r & (s2_id_r == REQ_DSP);
  assign pop0_s         = ~empty0_s & bus.rsp0_ready;
  assign pop1_s         = ~empty1_s & bus.rsp1_ready;
  assign bus.rsp0_valid = ~empty0_s;
  assign bus.rsp1_valid = ~empty1_s;

  sram_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo0 (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(push0_s), .push_data(bus.sram_R0_data),
    .pop(pop0_s), .pop_data(bus.rsp0_rdata), .count(cnt0_s), .empty(empty0_s), .full(full0_s)
  );

  sram_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo1 (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(push1_s), .push_data(bus.sram_R0_data),
    .pop(pop1_s), .pop_data(bus.rsp1_rdata), .count(cnt1_s), .empty(empty1_s), .full(full1_s)
  );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random checks of sram_port_arbiter against a behavioural SRAM and reference memory.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   i0, i1, k;

  logic [31:0] sram_mem [256];
  logic [31:0] sram_q = 32'd0;
  logic [31:0] ref_mem [256];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        pv [2];
  logic        pwe [2];
  logic [7:0]  pa [2];
  logic [31:0] pd [2];
  logic [31:0] got;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RSP_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus)
  );

  // behavioural 1W/1R SRAM: read data appears the cycle after sram_R0_en
  always @(posedge clk) begin
    if (bus.sram_W0_en) sram_mem[bus.sram_W0_addr] <= bus.sram_W0_data;
    if (bus.sram_R0_en) sram_q <= sram_mem[bus.sram_R0_addr];
  end
  assign bus.sram_R0_data = sram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 32'h0;
  endtask

  task automatic do_read(input logic port, input logic [7:0] a, input logic [31:0] exp, input string tag);
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = a; bus.rsp1_ready = 1'b1;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = a; bus.rsp0_ready = 1'b1;
    end
    #1;
    chk({tag, "_ready"}, 32'(port ? bus.req1_ready : bus.req0_ready), 32'd1);
    tick();
    idle();
    chk({tag, "_r0en"}, 32'(bus.sram_R0_en), 32'd1);
    chk({tag, "_r0addr"}, 32'(bus.sram_R0_addr), 32'(a));
    tick();
    tick();
    chk({tag, "_rspv"}, 32'(port ? bus.rsp1_valid : bus.rsp0_valid), 32'd1);
    chk({tag, "_rdata"}, port ? bus.rsp1_rdata : bus.rsp0_rdata, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      sram_mem[a] = 32'd0;
      ref_mem[a]  = 32'd0;
    end
    rst = 1'b1;
    idle();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b1;
    @(negedge clk);
    tick();
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_w0en", 32'(bus.sram_W0_en), 32'd0);
    chk("rst_r0en", 32'(bus.sram_R0_en), 32'd0);
    chk("rst_w0addr", 32'(bus.sram_W0_addr), 32'd0);
    chk("rst_w0data", bus.sram_W0_data, 32'd0);
    chk("rst_r0addr", 32'(bus.sram_R0_addr), 32'd0);
    chk("rst_rsp0v", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1v", 32'(bus.rsp1_valid), 32'd0);
    rst = 1'b0;
    idle();
    tick();

    // single write then read-back
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 8'h10; bus.req0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr1_ready0", 32'(bus.req0_ready), 32'd1);
    chk("wr1_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("wr1_w0en", 32'(bus.sram_W0_en), 32'd1);
    chk("wr1_w0addr", 32'(bus.sram_W0_addr), 32'h10);
    chk("wr1_w0data", bus.sram_W0_data, 32'hDEADBEEF);
    do_read(1'b0, 8'h10, 32'hDEADBEEF, "rd1");
    #1;
    chk("idle_w0en", 32'(bus.sram_W0_en), 32'd0);
    chk("idle_r0en", 32'(bus.sram_R0_en), 32'd0);

    // fresh pointers, then both requesters write 8 words in contention
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 8; c++) begin
      bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 8'(i0); bus.req0_wdata = 32'hA0000000 | 32'(i0);
      bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 8'(4 + i1); bus.req1_wdata = 32'hB0000000 | 32'(i1);
      #1;
      chk("rr_ready0", 32'(bus.req0_ready), 32'((c % 2) == 0));
      chk("rr_ready1", 32'(bus.req1_ready), 32'((c % 2) == 1));
      tick();
      chk("rr_w0en", 32'(bus.sram_W0_en), 32'd1);
      chk("rr_w0addr", 32'(bus.sram_W0_addr), ((c % 2) == 1) ? 32'(4 + i1) : 32'(i0));
      if ((c % 2) == 1) i1++; else i0++;
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      do_read(1'(a % 2), 8'(a), (a < 4) ? (32'hA0000000 | 32'(a)) : (32'hB0000000 | 32'(a - 4)), "rb");
    end

    // write and read to the same address in one cycle: read deferred
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 8'h20; bus.req0_wdata = 32'h12345678;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h20;
    #1;
    chk("col_ready0", 32'(bus.req0_ready), 32'd1);
    chk("col_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("col_retry_ready1", 32'(bus.req1_ready), 32'd1);
    chk("col_w0addr", 32'(bus.sram_W0_addr), 32'h20);
    tick();
    idle();
    bus.rsp1_ready = 1'b1;
    chk("col_r0en", 32'(bus.sram_R0_en), 32'd1);
    tick();
    tick();
    chk("col_rspv", 32'(bus.rsp1_valid), 32'd1);
    chk("col_rdata", bus.rsp1_rdata, 32'h12345678);
    tick();

    // credit limit with rsp1 stalled
    bus.rsp1_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'(k);
      #1;
      chk("cr_ready1", 32'(bus.req1_ready), 32'(c < 4));
      tick();
      if (c < 4) k++;
    end
    idle();
    #1;
    chk("cr_full_rspv", 32'(bus.rsp1_valid), 32'd1);
    bus.rsp1_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("cr_drain_v", 32'(bus.rsp1_valid), 32'd1);
      chk("cr_drain_d", bus.rsp1_rdata, 32'hA0000000 | 32'(j));
      tick();
    end
    chk("cr_empty", 32'(bus.rsp1_valid), 32'd0);
    do_read(1'b1, 8'h04, 32'hB0000000, "cr_resume");

    // reset with two reads in flight
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h00;
    #1;
    chk("rif_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    idle();
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h01;
    #1;
    chk("rif_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rif_pre_r0en", 32'(bus.sram_R0_en), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rif_r0en", 32'(bus.sram_R0_en), 32'd0);
    chk("rif_w0en", 32'(bus.sram_W0_en), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("rif_rsp0v", 32'(bus.rsp0_valid), 32'd0);
      chk("rif_rsp1v", 32'(bus.rsp1_valid), 32'd0);
      tick();
    end
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 8'h30; bus.req0_wdata = 32'h0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 8'h31; bus.req1_wdata = 32'h0;
    #1;
    chk("rif_prio0", 32'(bus.req0_ready), 32'd1);
    chk("rif_prio1", 32'(bus.req1_ready), 32'd0);
    tick();
    idle();
    tick();

    // random mixed traffic on 0x80..0x87 against a reference memory
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int c = 0; c < 330; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && (c < 300) && ($urandom_range(0, 2) != 0)) begin
          pv[r]  = 1'b1;
          pwe[r] = 1'($urandom_range(0, 1));
          pa[r]  = 8'h80 + 8'($urandom_range(0, 7));
          pd[r]  = $urandom;
        end
      end
      bus.req0_valid = pv[0]; bus.req0_we = pwe[0]; bus.req0_addr = pa[0]; bus.req0_wdata = pd[0];
      bus.req1_valid = pv[1]; bus.req1_we = pwe[1]; bus.req1_addr = pa[1]; bus.req1_wdata = pd[1];
      bus.rsp0_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
      #1;
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        chk("rnd_rsp0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          got = q0.pop_front();
          chk("rnd_rsp0_data", bus.rsp0_rdata, got);
        end
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        chk("rnd_rsp1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          got = q1.pop_front();
          chk("rnd_rsp1_data", bus.rsp1_rdata, got);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (pv[r] && pwe[r] && ((r == 1) ? bus.req1_ready : bus.req0_ready)) begin
          ref_mem[pa[r]] = pd[r];
          pv[r] = 1'b0;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (pv[r] && !pwe[r] && ((r == 1) ? bus.req1_ready : bus.req0_ready)) begin
          if (r == 1) q1.push_back(ref_mem[pa[r]]);
          else q0.push_back(ref_mem[pa[r]]);
          pv[r] = 1'b0;
        end
      end
      tick();
    end
    idle();
    chk("rnd_q0_drained", 32'(q0.size()), 32'd0);
    chk("rnd_q1_drained", 32'(q1.size()), 32'd0);
    chk("rnd_pend0", 32'(pv[0]), 32'd0);
    chk("rnd_pend1", 32'(pv[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
